// File: rtl/slot_pkg.sv
// Shared widths, amount constants and decoded-event type for the slot-machine
// balance logic.
package slot_pkg;

   localparam int unsigned W    = 11;
   localparam int unsigned MAXV = 2047;

   localparam int unsigned AMT_5  = 5;
   localparam int unsigned AMT_10 = 10;
   localparam int unsigned AMT_20 = 20;

   // One decoded button event per cycle, highest priority first in decode order
   typedef enum logic [2:0] {
      EV_NONE,
      EV_CASH,
      EV_ADD,
      EV_GAMBLE,
      EV_STATUS
   } ev_e;

endpackage

// File: rtl/balance_buttons_btn_edge.sv
// btn_edge: single-bit rising-edge detector. During reset the previous-value
// register tracks the input so a level held through reset never produces an edge.
module btn_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic evt
);

   logic prev_d;
   logic prev_q;

   // Next previous-value is always the current level, in and out of reset
   always_comb begin
      prev_d = btn;
   end

   // Previous-value register; reset preloads with the live input
   always_ff @(posedge clk) begin
      if (!rst_n) prev_q <= btn;
      else        prev_q <= prev_d;
   end

   assign evt = btn & ~prev_q;

endmodule

// File: rtl/balance_buttons.sv
// balance_buttons: credit/balance arithmetic for the slot-machine controller.
// Optional macro BALANCE_SATURATE_EN clamps add results at MAXV; without it
// add results wrap modulo 2^W.
module balance_buttons
   import slot_pkg::*;
#(
   parameter int unsigned W    = slot_pkg::W,
   parameter int unsigned MAXV = slot_pkg::MAXV
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         cash_out_btn,
   input  logic         add_btn,
   input  logic         gamble_btn,
   input  logic         status_btn,
   input  logic         buffer_5,
   input  logic         buffer_10,
   input  logic         buffer_20,
   input  logic [W-1:0] initial_money_invested,
   input  logic [W-1:0] initial_balance,
   output logic [W-1:0] final_money_invested,
   output logic [W-1:0] final_balance,
   output logic         run_game
);

   logic cash_evt, add_evt, gamble_evt, status_evt;

   btn_edge u_edge_cash   (.clk(clk), .rst_n(rst_n), .btn(cash_out_btn), .evt(cash_evt));
   btn_edge u_edge_add    (.clk(clk), .rst_n(rst_n), .btn(add_btn),      .evt(add_evt));
   btn_edge u_edge_gamble (.clk(clk), .rst_n(rst_n), .btn(gamble_btn),   .evt(gamble_evt));
   btn_edge u_edge_status (.clk(clk), .rst_n(rst_n), .btn(status_btn),   .evt(status_evt));

   ev_e          ev;
   logic [W-1:0] amt;
   logic [W-1:0] add_bal;
   logic [W-1:0] add_mi;
   logic [W-1:0] bal_d, bal_q;
   logic [W-1:0] mi_d,  mi_q;
   logic         run_d, run_q;

`ifdef BALANCE_SATURATE_EN
   logic [W:0] sum_bal;
   logic [W:0] sum_mi;
`endif

   // Decode amount select (20 > 10 > 5) and the single winning button event
   always_comb begin
      amt = '0;
      if (buffer_20)      amt = W'(AMT_20);
      else if (buffer_10) amt = W'(AMT_10);
      else if (buffer_5)  amt = W'(AMT_5);

      ev = EV_NONE;
      if (cash_evt)        ev = EV_CASH;
      else if (add_evt)    ev = EV_ADD;
      else if (gamble_evt) ev = EV_GAMBLE;
      else if (status_evt) ev = EV_STATUS;
   end

   // Deposit sums: clamped to MAXV or wrapped to W bits depending on build
   always_comb begin
`ifdef BALANCE_SATURATE_EN
      sum_bal = {1'b0, initial_balance}        + {1'b0, amt};
      sum_mi  = {1'b0, initial_money_invested} + {1'b0, amt};
      add_bal = (sum_bal > (W+1)'(MAXV)) ? W'(MAXV) : sum_bal[W-1:0];
      add_mi  = (sum_mi  > (W+1)'(MAXV)) ? W'(MAXV) : sum_mi[W-1:0];
`else
      add_bal = (initial_balance        + amt) & W'(MAXV);
      add_mi  = (initial_money_invested + amt) & W'(MAXV);
`endif
   end

   // Next-value selection for the registered outputs
   always_comb begin
      bal_d = initial_balance;
      mi_d  = initial_money_invested;
      run_d = 1'b0;
      unique case (ev)
         EV_CASH: begin
            bal_d = '0;
         end
         EV_ADD: begin
            bal_d = add_bal;
            mi_d  = add_mi;
         end
         EV_GAMBLE: begin
            if ((amt != '0) && (initial_balance >= amt)) begin
               bal_d = initial_balance - amt;
               run_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bal_q <= '0;
         mi_q  <= '0;
         run_q <= 1'b0;
      end else begin
         bal_q <= bal_d;
         mi_q  <= mi_d;
         run_q <= run_d;
      end
   end

   assign final_balance        = bal_q;
   assign final_money_invested = mi_q;
   assign run_game             = run_q;

endmodule

// File: tb/tb_balance_buttons.sv
// Bench for balance_buttons: directed steps from the test plan, then random
// stimulus, all checked against a behavioural model of the button rules.
module tb_balance_buttons;

   localparam int W = 11;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         cash_out_btn = 1'b0, add_btn = 1'b0, gamble_btn = 1'b0, status_btn = 1'b0;
   logic         buffer_5 = 1'b0, buffer_10 = 1'b0, buffer_20 = 1'b0;
   logic [W-1:0] initial_money_invested = '0;
   logic [W-1:0] initial_balance = '0;
   logic [W-1:0] final_money_invested;
   logic [W-1:0] final_balance;
   logic         run_game;

   int n_cmp  = 0;
   int n_fail = 0;

   // model: last sampled level of each button
   bit pc = 0, pa = 0, pg = 0, ps = 0;

   balance_buttons #(.W(11), .MAXV(2047)) dut (
      .clk(clk), .rst_n(rst_n),
      .cash_out_btn(cash_out_btn), .add_btn(add_btn),
      .gamble_btn(gamble_btn), .status_btn(status_btn),
      .buffer_5(buffer_5), .buffer_10(buffer_10), .buffer_20(buffer_20),
      .initial_money_invested(initial_money_invested),
      .initial_balance(initial_balance),
      .final_money_invested(final_money_invested),
      .final_balance(final_balance),
      .run_game(run_game)
   );

   always #5 clk = ~clk;

   function automatic int deposit(int s);
`ifdef BALANCE_SATURATE_EN
      return (s > 2047) ? 2047 : s;
`else
      return s % 2048;
`endif
   endfunction

   // Predict the outputs for the coming edge, take the edge, then compare.
   task automatic step(input string tag);
      int amt, ib, imi, eb, em, er;
      amt = buffer_20 ? 20 : buffer_10 ? 10 : buffer_5 ? 5 : 0;
      ib  = int'(initial_balance);
      imi = int'(initial_money_invested);
      eb = ib; em = imi; er = 0;
      if (!rst_n) begin
         eb = 0; em = 0;
      end else if (cash_out_btn && !pc) begin
         eb = 0;
      end else if (add_btn && !pa) begin
         eb = deposit(ib + amt);
         em = deposit(imi + amt);
      end else if (gamble_btn && !pg) begin
         if (amt != 0 && ib >= amt) begin
            eb = ib - amt;
            er = 1;
         end
      end
      pc = cash_out_btn; pa = add_btn; pg = gamble_btn; ps = status_btn;

      @(posedge clk);
      #1;
      n_cmp++;
      assert (final_balance === W'(eb)) else begin
         n_fail++;
         $error("FAIL %s final_balance got %0d expected %0d", tag, final_balance, eb);
      end
      n_cmp++;
      assert (final_money_invested === W'(em)) else begin
         n_fail++;
         $error("FAIL %s final_money_invested got %0d expected %0d", tag, final_money_invested, em);
      end
      n_cmp++;
      assert (run_game === 1'(er)) else begin
         n_fail++;
         $error("FAIL %s run_game got %0b expected %0d", tag, run_game, er);
      end
   endtask

   task automatic release_all();
      cash_out_btn = 0; add_btn = 0; gamble_btn = 0; status_btn = 0;
   endtask

   initial begin
      #1;
      step("reset0");
      step("reset1");
      rst_n = 1;
      step("idle");

      initial_balance = 0; initial_money_invested = 0; buffer_5 = 1; add_btn = 1;
      step("add5");
      step("add_held");

      buffer_10 = 1; gamble_btn = 1; initial_balance = 50;
      step("gamble10");
      step("gamble_held");
      gamble_btn = 0; buffer_20 = 1;
      step("gamble_release");
      gamble_btn = 1;
      step("gamble20");
      step("gamble20_held");

      release_all(); buffer_20 = 0; buffer_10 = 0; buffer_5 = 1;
      step("release");
      initial_balance = 3; gamble_btn = 1;
      step("gamble_reject");

      release_all();
      step("release2");
      initial_balance = 100; initial_money_invested = 120;
      cash_out_btn = 1; add_btn = 1;
      step("cash_beats_add");
      step("add_discarded");

      release_all(); buffer_20 = 1;
      step("release3");
      initial_balance = 2040; initial_money_invested = 2045; add_btn = 1;
      step("add_overflow");

      release_all(); step("release4");
      buffer_20 = 0; buffer_10 = 0; buffer_5 = 0; initial_balance = 7; add_btn = 1;
      step("add_amt0");
      release_all(); gamble_btn = 1;
      step("gamble_amt0");

      release_all(); buffer_5 = 1; initial_balance = 100;
      step("release5");
      gamble_btn = 1; rst_n = 0;
      step("held_in_reset");
      rst_n = 1;
      step("held_after_reset");
      step("held_after_reset2");
      gamble_btn = 0;
      step("gamble_release2");
      gamble_btn = 1;
      step("gamble_repress");

      status_btn = 1; gamble_btn = 0;
      step("status");

      for (int i = 0; i < 400; i++) begin
         rst_n        = ($urandom_range(0, 39) != 0);
         cash_out_btn = ($urandom_range(0, 5) == 0);
         add_btn      = ($urandom_range(0, 2) == 0);
         gamble_btn   = ($urandom_range(0, 2) == 0);
         status_btn   = ($urandom_range(0, 3) == 0);
         buffer_5     = $urandom_range(0, 1);
         buffer_10    = $urandom_range(0, 1);
         buffer_20    = $urandom_range(0, 1);
         if ($urandom_range(0, 3) == 0) begin
            initial_balance        = W'($urandom_range(2020, 2047));
            initial_money_invested = W'($urandom_range(2020, 2047));
         end else begin
            initial_balance        = W'($urandom_range(0, 2047));
            initial_money_invested = W'($urandom_range(0, 2047));
         end
         step("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
